// File: rtl/mips_cpu_pkg.sv
// Shared types and lane-enable helpers for the multicycle MIPS sequencer.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    MDWAIT = 3'd5,
    HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OTHER  = 3'd0,
    BRANCH = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    LINK   = 3'd4,
    MULDIV = 3'd5
  } iclass_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } msize_t;

  // Little-endian lanes; an undefined size code behaves as a word access.
  function automatic logic [3:0] calc_byteenable(msize_t size, logic [1:0] lo);
    case (size)
      BYTE:    return 4'b0001 << lo;
      HALF:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic is_aligned(msize_t size, logic [1:0] lo);
    case (size)
      BYTE:    return 1'b1;
      HALF:    return ~lo[0];
      default: return (lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_mc_sequencer_if.sv
// Avalon-style bus handshake between the sequencer and the memory side.
interface mips_cpu_mc_sequencer_if;
  logic       waitrequest;
  logic       read;
  logic       write;
  logic [3:0] byteenable;
  logic       iod;

  modport master (input waitrequest, output read, write, byteenable, iod);
  modport slave  (output waitrequest, input read, write, byteenable, iod);
endinterface

// File: rtl/mips_cpu_wait_watchdog.sv
// Counts consecutive stalled bus cycles and flags a timeout on the Nth one.
module mips_cpu_wait_watchdog #(
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic clk,
  input  logic srst,
  input  logic stall,
  input  logic clear,
  output logic timeout
);
  localparam int CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst || clear || !stall) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // cnt_reg holds the stalls already seen, so the current one is number cnt_reg+1.
  assign timeout = (WAIT_TIMEOUT != 0) && stall && (int'(cnt_reg) == WAIT_TIMEOUT - 1);
endmodule

// File: rtl/mips_cpu_mc_sequencer.sv
// Multicycle phase sequencer: bus handshakes, strobes, traps and perf counters.
module mips_cpu_mc_sequencer
  import mips_cpu_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR     = '0,
  parameter int                MULDIV_CYCLES = 1,
  parameter int                WAIT_TIMEOUT  = 0,
  parameter int                CNT_W         = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_cpu_mc_sequencer_if.master bus,
  input  logic [ADDR_W-1:0]      pc,
  input  iclass_t                instr_class,
  input  msize_t                 mem_size,
  input  logic [1:0]             addr_lo,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   br_en,
  output logic                   reg_write,
  output logic                   hilo_write,
  output state_t                 state,
  output logic                   active,
  output logic                   bus_err,
  output logic [CNT_W-1:0]       retired_count,
  output logic [CNT_W-1:0]       stall_count
);
  state_t           state_reg, state_next;
  logic             active_reg, bus_err_reg;
  logic [CNT_W-1:0] retired_reg, stall_reg;
  logic [7:0]       md_cnt_reg;

  logic       rd_strobe, wr_strobe, iod_sel, retire, err_set, md_load, stall, timeout;
  logic [3:0] be_lanes;

  assign stall = (rd_strobe | wr_strobe) & bus.waitrequest;

  mips_cpu_wait_watchdog #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .srst    (reset),
    .stall   (stall),
    .clear   (state_next != state_reg),
    .timeout (timeout)
  );

  always_comb begin
    state_next = state_reg;
    rd_strobe  = 1'b0;
    wr_strobe  = 1'b0;
    be_lanes   = 4'h0;
    iod_sel    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    br_en      = 1'b0;
    reg_write  = 1'b0;
    hilo_write = 1'b0;
    retire     = 1'b0;
    err_set    = 1'b0;
    md_load    = 1'b0;
    case (state_reg)
      FETCH: begin
        if (pc == HALT_ADDR) begin
          state_next = HALT;
        end else begin
          rd_strobe = 1'b1;
          be_lanes  = 4'hF;
          if (!bus.waitrequest) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = DECODE;
          end
        end
      end
      DECODE: state_next = EXEC;
      EXEC: begin
        case (instr_class)
          OTHER: begin
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
          end
          BRANCH: begin
            br_en      = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
          end
          LOAD, STORE: begin
            if (!is_aligned(mem_size, addr_lo)) begin
              err_set    = 1'b1;
              state_next = HALT;
            end else begin
              state_next = MEM;
            end
          end
          LINK: begin
            br_en      = 1'b1;
            state_next = WB;
          end
          MULDIV: begin
            if (MULDIV_CYCLES == 1) begin
              hilo_write = 1'b1;
              retire     = 1'b1;
              state_next = FETCH;
            end else begin
              md_load    = 1'b1;
              state_next = MDWAIT;
            end
          end
          default: begin
            retire     = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEM: begin
        iod_sel   = 1'b1;
        be_lanes  = calc_byteenable(mem_size, addr_lo);
        rd_strobe = (instr_class == LOAD);
        wr_strobe = (instr_class != LOAD);
        if (!bus.waitrequest) begin
          if (instr_class == LOAD) begin
            state_next = WB;
          end else begin
            retire     = 1'b1;
            state_next = FETCH;
          end
        end
      end
      WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MDWAIT: begin
        if (md_cnt_reg == 8'd0) begin
          hilo_write = 1'b1;
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
    // Strobes stay up during the timeout cycle and drop once HALT is entered.
    if (timeout) begin
      err_set    = 1'b1;
      state_next = HALT;
    end
    if (reset) begin
      state_next = FETCH;
      rd_strobe  = 1'b0;
      wr_strobe  = 1'b0;
      be_lanes   = 4'h0;
      iod_sel    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      br_en      = 1'b0;
      reg_write  = 1'b0;
      hilo_write = 1'b0;
      retire     = 1'b0;
      err_set    = 1'b0;
      md_load    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= FETCH;
      active_reg  <= 1'b1;
      bus_err_reg <= 1'b0;
      retired_reg <= '0;
      stall_reg   <= '0;
      md_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next == HALT) active_reg <= 1'b0;
      if (err_set) bus_err_reg <= 1'b1;
      if (retire) retired_reg <= retired_reg + CNT_W'(1);
      if (stall) stall_reg <= stall_reg + CNT_W'(1);
      if (md_load) begin
        md_cnt_reg <= 8'(MULDIV_CYCLES - 2);
      end else if (state_reg == MDWAIT) begin
        md_cnt_reg <= md_cnt_reg - 8'd1;
      end
    end
  end

  assign bus.read       = rd_strobe;
  assign bus.write      = wr_strobe;
  assign bus.byteenable = be_lanes;
  assign bus.iod        = iod_sel;
  assign state          = state_reg;
  assign active         = active_reg;
  assign bus_err        = bus_err_reg;
  assign retired_count  = retired_reg;
  assign stall_count    = stall_reg;
endmodule
